// File: rtl/ext_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ext_shift_pkg
//  Purpose  : Shared mode encodings, snapshot FSM states and beat-count helper
//             for the multi-channel shift bank.
//  Revision : 1.0 - initial release
// ============================================================================
package ext_shift_pkg;

    // Datapath operating modes
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Snapshot readout FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } snap_state_t;

    // Number of readout beats needed to cover every channel bit
    function automatic int calc_nbeats(input int width, input int channels, input int scan_w);
        return (width * channels + scan_w - 1) / scan_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_snap_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : ext_snap_serializer
//  Purpose  : Captures the full channel state into a shadow buffer on request
//             and streams it out as SCAN_W-bit valid/ready beats, low bits
//             first, with zero padding above the last real bit.
//  Revision : 1.0 - initial release
// ============================================================================
module ext_snap_serializer
    import ext_shift_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 1,
    parameter int SCAN_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         snap_req,
    input  logic [CHANNELS*WIDTH-1:0]    snap_data,
    output logic                         snap_busy,
    output logic                         scan_valid,
    input  logic                         scan_ready,
    output logic [SCAN_W-1:0]            scan_data,
    output logic                         scan_last
);

    localparam int C_TOTAL  = WIDTH * CHANNELS;
    localparam int C_NBEATS = calc_nbeats(WIDTH, CHANNELS, SCAN_W);
    localparam int C_PAD_W  = C_NBEATS * SCAN_W;
    localparam int C_IDX_W  = (C_NBEATS > 1) ? $clog2(C_NBEATS) : 1;

    snap_state_t          r_state;
    snap_state_t          w_state_nxt;
    logic [C_IDX_W-1:0]   r_idx;
    logic [C_IDX_W-1:0]   w_idx_nxt;
    logic [C_PAD_W-1:0]   r_shadow;
    logic [C_PAD_W-1:0]   w_capture;
    logic                 w_capture_en;
    logic                 w_last;
    logic [SCAN_W-1:0]    w_beat;

    // Shadow is stored pre-padded so every beat is a plain slice
    always_comb begin
        w_capture                = '0;
        w_capture[C_TOTAL-1:0]   = snap_data;
    end

    // Beat select: pick the shadow slice addressed by the beat index
    always_comb begin
        w_beat = '0;
        for (int b = 0; b < C_NBEATS; b++) begin
            if (r_idx == C_IDX_W'(b)) begin
                w_beat = r_shadow[b*SCAN_W +: SCAN_W];
            end
        end
    end

    assign w_last = (r_idx == C_IDX_W'(C_NBEATS - 1));

    // Next-state logic; a request while sending is simply not looked at
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_capture_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (snap_req) begin
                    w_state_nxt  = ST_SEND;
                    w_idx_nxt    = '0;
                    w_capture_en = 1'b1;
                end
            end
            ST_SEND: begin
                if (scan_ready) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + C_IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, index and shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_shadow <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_capture_en) begin
                r_shadow <= w_capture;
            end
        end
    end

    // Outputs are decoded from registers only, so they hold under backpressure
    always_comb begin
        scan_valid = (r_state == ST_SEND);
        snap_busy  = (r_state == ST_SEND);
        scan_last  = (r_state == ST_SEND) && w_last;
        scan_data  = (r_state == ST_SEND) ? w_beat : '0;
    end

endmodule
`default_nettype wire

// File: rtl/ext_shift_bank.sv
`default_nettype none
// ============================================================================
//  Module   : ext_shift_bank
//  Purpose  : CHANNELS independent WIDTH-bit shift registers (hold, shift
//             left, shift right, parallel load) with a non-stalling snapshot
//             readout port.
//  Revision : 1.0 - initial release
// ============================================================================
module ext_shift_bank
    import ext_shift_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 1,
    parameter int SCAN_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS-1:0]          din,
    input  logic [CHANNELS*WIDTH-1:0]    load_data,
    output logic [CHANNELS-1:0]          dout,
    output logic [CHANNELS*WIDTH-1:0]    data_q,
    input  logic                         snap_req,
    output logic                         snap_busy,
    output logic                         scan_valid,
    input  logic                         scan_ready,
    output logic [SCAN_W-1:0]            scan_data,
    output logic                         scan_last
);

    logic [WIDTH-1:0] w_ch [CHANNELS];

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [WIDTH-1:0] r_reg;

            // Per-channel register with mode mux; en=0 freezes the channel
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_reg <= '0;
                end else if (en) begin
                    case (mode)
                        MODE_SHL:  r_reg <= {r_reg[WIDTH-2:0], din[c]};
                        MODE_SHR:  r_reg <= {din[c], r_reg[WIDTH-1:1]};
                        MODE_LOAD: r_reg <= load_data[c*WIDTH +: WIDTH];
                        default:   r_reg <= r_reg;
                    endcase
                end
            end

            assign w_ch[c] = r_reg;
        end
    endgenerate

    // Pack channel registers onto the flat outputs
    always_comb begin
        data_q = '0;
        dout   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            data_q[c*WIDTH +: WIDTH] = w_ch[c];
            dout[c]                  = w_ch[c][WIDTH-1];
        end
    end

    // Snapshot sees the registered (pre-edge) state, so a shift on the
    // capture edge does not leak into the shadow
    ext_snap_serializer #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SCAN_W   (SCAN_W)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .snap_req   (snap_req),
        .snap_data  (data_q),
        .snap_busy  (snap_busy),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .scan_data  (scan_data),
        .scan_last  (scan_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_ext_shift_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_shift_bank
//  Purpose  : Self-checking bench for ext_shift_bank in three configurations:
//             legacy 32x1, 8x2 mode checks, 8x3/16-bit readout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ext_shift_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- config A: WIDTH=32, CHANNELS=1 ----------------
    logic        a_en, a_din, a_dout, a_busy, a_valid, a_last;
    logic [1:0]  a_mode;
    logic [31:0] a_load, a_data_q, a_scan_data;

    ext_shift_bank #(.WIDTH(32), .CHANNELS(1), .SCAN_W(32)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .din(a_din),
        .load_data(a_load), .dout(a_dout), .data_q(a_data_q),
        .snap_req(1'b0), .snap_busy(a_busy), .scan_valid(a_valid),
        .scan_ready(1'b1), .scan_data(a_scan_data), .scan_last(a_last)
    );

    // ---------------- config B: WIDTH=8, CHANNELS=2 ----------------
    logic        b_en, b_busy, b_valid, b_last;
    logic [1:0]  b_mode, b_din, b_dout;
    logic [15:0] b_load, b_data_q, b_scan_data;

    ext_shift_bank #(.WIDTH(8), .CHANNELS(2), .SCAN_W(16)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .din(b_din),
        .load_data(b_load), .dout(b_dout), .data_q(b_data_q),
        .snap_req(1'b0), .snap_busy(b_busy), .scan_valid(b_valid),
        .scan_ready(1'b1), .scan_data(b_scan_data), .scan_last(b_last)
    );

    // ---------------- config C: WIDTH=8, CHANNELS=3, SCAN_W=16 ----------------
    logic        c_en, c_snap, c_busy, c_valid, c_ready, c_last;
    logic [1:0]  c_mode;
    logic [2:0]  c_din, c_dout;
    logic [23:0] c_load, c_data_q;
    logic [15:0] c_scan_data;

    ext_shift_bank #(.WIDTH(8), .CHANNELS(3), .SCAN_W(16)) u_c (
        .clk(clk), .rst(rst), .en(c_en), .mode(c_mode), .din(c_din),
        .load_data(c_load), .dout(c_dout), .data_q(c_data_q),
        .snap_req(c_snap), .snap_busy(c_busy), .scan_valid(c_valid),
        .scan_ready(c_ready), .scan_data(c_scan_data), .scan_last(c_last)
    );

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [15:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        sb.push_back(b);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((c_busy || sb.size() != 0) && n < 40) begin
            step();
            n++;
        end
        tests++;
        if (n >= 40) begin
            fails++;
            $display("FAIL %s: timeout, busy=%0b pending=%0d expected idle/0", name, c_busy, sb.size());
        end
    endtask

    // Monitor: compare every presented beat against the head of the scoreboard;
    // pop only when the beat is accepted, so held beats are rechecked each cycle
    always @(negedge clk) begin
        if (!rst && c_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got data %h last %0b, expected no beat", c_scan_data, c_last);
            end else begin
                check("beat_data", 32'(c_scan_data), 32'(sb[0].d));
                check("beat_last", 32'(c_last), 32'(sb[0].l));
                check("beat_busy", 32'(c_busy), 32'd1);
                if (c_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] exp_a;

        a_en = 0; a_mode = 0; a_din = 0; a_load = 0;
        b_en = 0; b_mode = 0; b_din = 0; b_load = 0;
        c_en = 0; c_mode = 0; c_din = 0; c_load = 0; c_snap = 0; c_ready = 1;
        rst = 1;
        step();
        step();
        rst = 0;

        // Reset state
        check("rst_a_data_q", a_data_q, 32'h0);
        check("rst_b_data_q", 32'(b_data_q), 32'h0);
        check("rst_c_data_q", 32'(c_data_q), 32'h0);
        check("rst_c_valid", 32'(c_valid), 32'h0);
        check("rst_c_busy", 32'(c_busy), 32'h0);
        check("rst_c_scan_data", 32'(c_scan_data), 32'h0);
        check("rst_c_last", 32'(c_last), 32'h0);

        // Legacy: shift ones in from the right for 32+ cycles
        a_en = 1; a_mode = 2'b01; a_din = 1;
        exp_a = 32'h0;
        for (int i = 1; i <= 34; i++) begin
            step();
            exp_a = {exp_a[30:0], 1'b1};
            check("a_shl_data_q", a_data_q, exp_a);
            check("a_shl_dout", 32'(a_dout), (i >= 32) ? 32'd1 : 32'd0);
        end
        a_en = 0;

        // Modes on 8x2
        b_en = 1; b_mode = 2'b11; b_load = 16'hA55A;
        step();
        check("b_load", 32'(b_data_q), 32'h0000A55A);
        check("b_load_dout", 32'(b_dout), 32'h2);
        b_mode = 2'b10; b_din = 2'b00;
        step();
        check("b_shr", 32'(b_data_q), 32'h0000522D);
        check("b_shr_dout", 32'(b_dout), 32'h0);
        b_en = 0; b_mode = 2'b01; b_din = 2'b11;
        step();
        step();
        check("b_en0_hold", 32'(b_data_q), 32'h0000522D);
        b_en = 1; b_din = 2'b01;
        step();
        check("b_shl", 32'(b_data_q), 32'h0000A45B);
        b_mode = 2'b00; b_din = 2'b11;
        step();
        check("b_hold_mode", 32'(b_data_q), 32'h0000A45B);
        b_en = 0;

        // Readout with ready held high
        c_en = 1; c_mode = 2'b11; c_load = 24'hC3B2A1;
        step();
        c_en = 0;
        check("c_load", 32'(c_data_q), 32'h00C3B2A1);
        push_beat(16'hB2A1, 1'b0);
        push_beat(16'h00C3, 1'b1);
        c_ready = 1; c_snap = 1;
        step();
        c_snap = 0;
        check("c_snap_busy_on", 32'(c_busy), 32'd1);
        wait_drain("readout_drain");
        check("c_busy_after", 32'(c_busy), 32'd0);
        check("c_valid_after", 32'(c_valid), 32'd0);

        // Backpressure with a load on the capture edge
        push_beat(16'hB2A1, 1'b0);
        push_beat(16'h00C3, 1'b1);
        c_ready = 0; c_snap = 1; c_en = 1; c_mode = 2'b11; c_load = 24'hFFFFFF;
        step();
        c_snap = 0; c_en = 0;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("bp_data_q", 32'(c_data_q), 32'h00FFFFFF);
        check("bp_beat0_held", 32'(c_scan_data), 32'h0000B2A1);
        check("bp_last_held", 32'(c_last), 32'd0);
        c_ready = 1;
        wait_drain("bp_drain");

        // Requests during SEND and on the last-beat edge are ignored
        push_beat(16'hFFFF, 1'b0);
        push_beat(16'h00FF, 1'b1);
        c_ready = 0; c_snap = 1;
        step();
        c_snap = 0;
        step();
        c_snap = 1; c_en = 1; c_mode = 2'b11; c_load = 24'h123456;
        step();
        c_snap = 0; c_en = 0;
        check("ign_data_q", 32'(c_data_q), 32'h00123456);
        c_ready = 1;
        step();
        check("ign_last_pending", 32'(c_last), 32'd1);
        c_snap = 1;
        step();
        c_snap = 0;
        check("ign_idle_after_last", 32'(c_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("ign_no_second", 32'(c_valid), 32'd0);
        check("ign_queue_empty", 32'(sb.size()), 32'd0);

        // Reset aborts a readout in progress
        push_beat(16'h3456, 1'b0);
        push_beat(16'h0012, 1'b1);
        c_ready = 0; c_snap = 1;
        step();
        c_snap = 0;
        step();
        check("abort_pre_valid", 32'(c_valid), 32'd1);
        rst = 1;
        step();
        check("abort_valid", 32'(c_valid), 32'd0);
        check("abort_busy", 32'(c_busy), 32'd0);
        check("abort_data_q", 32'(c_data_q), 32'h0);
        check("abort_scan_data", 32'(c_scan_data), 32'h0);
        sb.delete();
        rst = 0;
        c_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("abort_stays_idle", 32'(c_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_shift_bank.md
Name: ext_shift_bank

Overview:
- Parametrised, multi-channel successor to the single 32-bit serial-in shift register.
- Holds CHANNELS independent WIDTH-bit shift registers with hold, shift-left, shift-right and parallel-load modes.
- Adds a snapshot/readout port: one request captures all channel state into a shadow buffer. The buffer is then streamed out over a valid/ready beat interface, so register state can be read externally without stalling the shift datapath.
- Sits directly under the datapath hierarchy, driven by the same clock, reset and enable as the legacy shift register.

Parameters:
- WIDTH, 32, bits per channel register (>= 2)
- CHANNELS, 1, number of independent shift registers (>= 1)
- SCAN_W, 32, readout beat width in bits (1 .. CHANNELS*WIDTH)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  datapath update enable
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
- din  input  CHANNELS  serial input bit per channel
- load_data  input  CHANNELS*WIDTH  parallel load value; channel c at [c*WIDTH +: WIDTH]
- dout  output  CHANNELS  dout[c] = data[c][WIDTH-1] (combinational from register)
- data_q  output  CHANNELS*WIDTH  full register contents, same packing as load_data
- snap_req  input  1  single-cycle snapshot request
- snap_busy  output  1  high while a readout is in progress
- scan_valid  output  1  readout beat valid
- scan_ready  input  1  readout beat accepted
- scan_data  output  SCAN_W  readout beat
- scan_last  output  1  marks final beat of a snapshot

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all channel registers 0; shadow 0; FSM IDLE; snap_busy, scan_valid and scan_last 0; scan_data 0. Reset mid-readout aborts the readout with no further beats.
- Datapath per channel c, updated on the rising edge only when en=1:
  - 00: hold.
  - 01: data <= {data[WIDTH-2:0], din[c]}.
  - 10: data <= {din[c], data[WIDTH-1:1]}.
  - 11: data <= load_data slice.
  - en=0: hold regardless of mode.
- Datapath latency: 1 cycle. dout and data_q reflect the new value the cycle after the edge.
- Snapshot FSM, states IDLE and SEND:
  - IDLE with snap_req=1: shadow <= data_q (the pre-edge value, even if a shift occurs on the same edge). Beat index <= 0. Go to SEND.
  - SEND: scan_valid=1, snap_busy=1. scan_data = shadow[idx*SCAN_W +: SCAN_W]; bits beyond CHANNELS*WIDTH read as 0 (last-beat zero padding).
  - NBEATS = ceil(CHANNELS*WIDTH / SCAN_W).
  - scan_last = 1 when idx == NBEATS-1.
  - On scan_valid & scan_ready: if last, go to IDLE (valid drops the next cycle); else idx+1.
  - scan_data and scan_last are held stable while valid & !ready.
  - snap_req during SEND is ignored; no queuing.
  - snap_req on the same edge the last beat is accepted is ignored; the FSM returns to IDLE.
- The shift datapath is never stalled by readout. Shadow contents are frozen until the next snapshot.
- Index counter width: clog2(NBEATS), minimum 1 bit.

Decomposition:
- Package ext_shift_pkg holds:
  - mode constants MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD (2-bit);
  - FSM state enum (ST_IDLE, ST_SEND);
  - a function computing NBEATS from WIDTH, CHANNELS and SCAN_W.
- One sub-module, ext_snap_serializer, contains the shadow buffer, beat FSM, index counter and padding.
- The top level contains the channel register array, mode mux and serializer instance.

Test Plan:
- Reset and legacy mode: WIDTH=32, CHANNELS=1; after rst, data_q=0. en=1, mode=01, din=1 for 32 cycles: data_q=32'hFFFFFFFF, dout=1 from cycle 32 onward.
- Modes: WIDTH=8, CHANNELS=2. Load 16'hA55A, then mode=10 with din=2'b00: channel1 0xA5->0x52, channel0 0x5A->0x2D. Then en=0 with mode=01: data_q unchanged.
- Readout: WIDTH=8, CHANNELS=3, SCAN_W=16, data_q=24'hC3B2A1, scan_ready=1. snap_req gives beat0=16'hB2A1 (last=0), then beat1=16'h00C3 (last=1); snap_busy drops after beat1.
- Backpressure plus concurrent shift: same config. snap_req on the same edge as a load of 24'hFFFFFF. Hold scan_ready=0 for 5 cycles. Beat0 stays 16'hB2A1 and stable; the shadow shows the pre-load value; data_q=24'hFFFFFF.
- Ignored request and reset abort: pulse snap_req during SEND, and no second snapshot follows the first. Assert rst while scan_valid=1: the next cycle has scan_valid=0, snap_busy=0 and data_q=0.
